// File: rtl/fdiv_prog_ctrl.sv
// Programmable glitch-free clock divider. Ratio changes and start/stop requests
// take effect only at an output period boundary, so the output never carries a runt pulse.
module fdiv_prog_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             out,
    output logic             tc,
    output logic             running
);

    typedef enum logic [1:0] {
        STOP     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] div_pend;
    logic             pend;
    logic             active;
    logic             wrap;
    logic             accept;

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < TWO) ? TWO : d;
    endfunction

    assign active = (state != STOP);
    assign wrap   = active && (count == div_cur - ONE);
    assign accept = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= STOP;
            count     <= '0;
            div_cur   <= DIV_RST;
            pend      <= 1'b0;
            cfg_ready <= 1'b1;
            out       <= 1'b0;
            tc        <= 1'b0;
            running   <= 1'b0;
        end else begin
            out <= active && (count < (div_cur >> 1));
            tc  <= wrap;

            case (state)
                STOP: begin
                    count   <= '0;
                    running <= en;
                    if (en) state <= RUN;
                end
                RUN: begin
                    count   <= wrap ? '0 : count + ONE;
                    running <= 1'b1;
                    if (!en) state <= STOPPING;
                end
                STOPPING: begin
                    count   <= wrap ? '0 : count + ONE;
                    running <= en || !wrap;
                    if (en)        state <= RUN;
                    else if (wrap) state <= STOP;
                end
                default: begin
                    state   <= STOP;
                    count   <= '0;
                    running <= 1'b0;
                end
            endcase

            // A pending ratio is only swapped in on a wrap, so a period never changes length midway.
            if (wrap && pend) begin
                div_cur   <= div_pend;
                pend      <= 1'b0;
                cfg_ready <= 1'b1;
            end else if (accept) begin
                if (active) begin
                    pend      <= 1'b1;
                    cfg_ready <= 1'b0;
                end else begin
                    div_cur <= clamp_div(cfg_div);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && active) div_pend <= clamp_div(cfg_div);
    end

endmodule
